// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed 64-bit data memory with programmable wait states.
// Build option DMEM_ALIGN_CHECK_EN: fault any access whose address is not 8-byte aligned.
module dmem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int AW          = 64
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [63:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [63:0]   rsp_rdata,
   output logic          rsp_err
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   state_t        state, stateNext;
   logic [3:0]    waitCnt, waitCntNext;
   logic [AW-4:0] addrHiQ;
   logic          wrQ;
   logic [63:0]   wdataQ;
   logic [63:0]   mem [DEPTH];
   logic [IW-1:0] idx;
   logic          rangeErr;
   logic          fault;
   logic          hs;

   assign hs       = req_valid && req_ready;
   assign idx      = addrHiQ[IW-1:0];
   assign rangeErr = |addrHiQ[AW-4:IW];

`ifdef DMEM_ALIGN_CHECK_EN
   logic misQ;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         misQ <= 1'b0;
      end else if (hs) begin
         misQ <= |req_addr[2:0];
      end
   end

   assign fault = rangeErr | misQ;
`else
   // Low address bits select a byte within the word and are ignored here.
   logic unusedLowAddr;
   assign unusedLowAddr = ^req_addr[2:0];
   assign fault         = rangeErr;
`endif

   always_comb begin
      stateNext   = state;
      waitCntNext = waitCnt;
      unique case (state)
         IDLE: begin
            if (hs) begin
               if (WAIT_CYCLES > 0) begin
                  stateNext   = WAIT;
                  waitCntNext = WAIT_LOAD;
               end else begin
                  stateNext = ACCESS;
               end
            end
         end
         WAIT: begin
            if (waitCnt == 4'd0) begin
               stateNext = ACCESS;
            end else begin
               waitCntNext = waitCnt - 4'd1;
            end
         end
         ACCESS: stateNext = RESP;
         RESP: begin
            if (rsp_ready) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         waitCnt   <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         addrHiQ   <= '0;
         wrQ       <= 1'b0;
         wdataQ    <= '0;
      end else begin
         state     <= stateNext;
         waitCnt   <= waitCntNext;
         req_ready <= (stateNext == IDLE);
         rsp_valid <= (stateNext == RESP);
         if (hs) begin
            addrHiQ <= req_addr[AW-1:3];
            wrQ     <= req_write;
            wdataQ  <= req_wdata;
         end
         if (state == ACCESS) begin
            rsp_err   <= fault;
            rsp_rdata <= (fault || wrQ) ? '0 : mem[idx];
         end else if (state == RESP && rsp_ready) begin
            rsp_err <= 1'b0;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (state == ACCESS && wrQ && !fault) begin
         mem[idx] <= wdataQ;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Instance A uses WAIT_CYCLES=2, instance B uses WAIT_CYCLES=0.
module tb_dmem_responder;
   localparam int AW = 64;
   localparam int W[2] = '{2, 0};

   typedef struct {
      logic [63:0] data;
      logic        err;
   } exp_t;

   logic          clk;
   logic          rstn;
   logic          reqValid [2];
   logic          reqReady [2];
   logic          reqWrite [2];
   logic [AW-1:0] reqAddr  [2];
   logic [63:0]   reqWdata [2];
   logic          rspValid [2];
   logic          rspReady [2];
   logic [63:0]   rspRdata [2];
   logic          rspErr   [2];

   exp_t sb[$];
   int   checks;
   int   errors;
   time  hsTime;
   time  t0;

   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2), .AW(AW)) uDutA (
      .clk      (clk),
      .rstn     (rstn),
      .req_valid(reqValid[0]),
      .req_ready(reqReady[0]),
      .req_write(reqWrite[0]),
      .req_addr (reqAddr[0]),
      .req_wdata(reqWdata[0]),
      .rsp_valid(rspValid[0]),
      .rsp_ready(rspReady[0]),
      .rsp_rdata(rspRdata[0]),
      .rsp_err  (rspErr[0])
   );

   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .AW(AW)) uDutB (
      .clk      (clk),
      .rstn     (rstn),
      .req_valid(reqValid[1]),
      .req_ready(reqReady[1]),
      .req_write(reqWrite[1]),
      .req_addr (reqAddr[1]),
      .req_wdata(reqWdata[1]),
      .rsp_valid(rspValid[1]),
      .rsp_ready(rspReady[1]),
      .rsp_rdata(rspRdata[1]),
      .rsp_err  (rspErr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   // Called at a negedge; returns at the negedge after the response retires.
   task automatic access(input int d, input bit wr, input logic [63:0] addr,
                         input logic [63:0] data, input logic [63:0] expData,
                         input bit expErr, input int hold);
      exp_t        e;
      int          k;
      logic [63:0] held;
      sb.push_back('{expData, expErr});
      reqValid[d] = 1'b1;
      reqWrite[d] = wr;
      reqAddr[d]  = addr;
      reqWdata[d] = data;
      if (hold > 0) rspReady[d] = 1'b0;
      k = 0;
      while (!reqReady[d] && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("req_ready_before_hs", 64'(reqReady[d]), 64'(1));
      @(posedge clk);
      hsTime = $time;
      @(negedge clk);
      reqValid[d] = 1'b0;
      k = 0;
      while (!rspValid[d] && k < 30) begin
         @(negedge clk);
         k++;
      end
      e = sb.pop_front();
      check("latency", 64'(k + 1), 64'(2 + W[d]));
      check("rsp_err", 64'(rspErr[d]), 64'(e.err));
      check("rsp_rdata", rspRdata[d], e.data);
      held = rspRdata[d];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bp_rsp_valid", 64'(rspValid[d]), 64'(1));
         check("bp_rsp_rdata", rspRdata[d], held);
         check("bp_req_ready", 64'(reqReady[d]), 64'(0));
      end
      rspReady[d] = 1'b1;
      @(negedge clk);
      check("done_rsp_valid", 64'(rspValid[d]), 64'(0));
      check("done_req_ready", 64'(reqReady[d]), 64'(1));
      check("done_rsp_err", 64'(rspErr[d]), 64'(0));
   endtask

   initial begin
      int k;
      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      for (int d = 0; d < 2; d++) begin
         reqValid[d] = 1'b0;
         reqWrite[d] = 1'b0;
         reqAddr[d]  = '0;
         reqWdata[d] = '0;
         rspReady[d] = 1'b1;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         check("rst_req_ready", 64'(reqReady[d]), 64'(1));
         check("rst_rsp_valid", 64'(rspValid[d]), 64'(0));
         check("rst_rsp_rdata", rspRdata[d], 64'(0));
         check("rst_rsp_err", 64'(rspErr[d]), 64'(0));
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Basic store/load, then the same load under backpressure.
      access(0, 1, 64'h40, 64'h0123456789ABCDEF, 64'h0, 0, 0);
      access(0, 0, 64'h40, 64'h0, 64'h0123456789ABCDEF, 0, 0);
      access(0, 0, 64'h40, 64'h0, 64'h0123456789ABCDEF, 0, 5);

      // Range boundary and out-of-range store.
      access(0, 1, 64'h0, 64'h55, 64'h0, 0, 0);
      access(0, 1, 64'h800, 64'hFF, 64'h0, 1, 0);
      access(0, 0, 64'h800, 64'h0, 64'h0, 1, 0);
      access(0, 0, 64'h0, 64'h0, 64'h55, 0, 0);
      access(0, 1, 64'h7F8, 64'hDEAD_BEEF, 64'h0, 0, 0);
      access(0, 0, 64'h7F8, 64'h0, 64'hDEAD_BEEF, 0, 0);
      access(0, 1, 64'h10, 64'h1010, 64'h0, 0, 0);

      // Misaligned store into word 8.
`ifdef DMEM_ALIGN_CHECK_EN
      access(0, 1, 64'h43, 64'hAA, 64'h0, 1, 0);
      access(0, 0, 64'h40, 64'h0, 64'h0123456789ABCDEF, 0, 0);
`else
      access(0, 1, 64'h43, 64'hAA, 64'h0, 0, 0);
      access(0, 0, 64'h40, 64'h0, 64'hAA, 0, 0);
`endif

      // Reset while a store sits in WAIT.
      reqValid[0] = 1'b1;
      reqWrite[0] = 1'b1;
      reqAddr[0]  = 64'h10;
      reqWdata[0] = 64'h77;
      k = 0;
      while (!reqReady[0] && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      @(negedge clk);
      reqValid[0] = 1'b0;
      check("pre_rst_req_ready", 64'(reqReady[0]), 64'(0));
      rstn = 1'b0;
      #1;
      check("mid_rst_req_ready", 64'(reqReady[0]), 64'(1));
      check("mid_rst_rsp_valid", 64'(rspValid[0]), 64'(0));
      check("mid_rst_rsp_rdata", rspRdata[0], 64'(0));
      check("mid_rst_rsp_err", 64'(rspErr[0]), 64'(0));
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      access(0, 0, 64'h10, 64'h0, 64'h1010, 0, 0);

      // Zero wait states, back-to-back with interleaved data.
      access(1, 1, 64'h08, 64'hA5A5_0000_1111_2222, 64'h0, 0, 0);
      t0 = hsTime;
      access(1, 0, 64'h08, 64'h0, 64'hA5A5_0000_1111_2222, 0, 0);
      check("period_1", 64'((hsTime - t0) / 10), 64'(3));
      t0 = hsTime;
      access(1, 1, 64'h10, 64'h5A5A_3333_4444_5555, 64'h0, 0, 0);
      check("period_2", 64'((hsTime - t0) / 10), 64'(3));
      t0 = hsTime;
      access(1, 0, 64'h08, 64'h0, 64'hA5A5_0000_1111_2222, 0, 0);
      check("period_3", 64'((hsTime - t0) / 10), 64'(3));
      access(1, 0, 64'h10, 64'h0, 64'h5A5A_3333_4444_5555, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
